// File: rtl/gb_cart_pkg.sv
// Shared cartridge-bus definitions: region bounds, MBC register layout.
package gb_cart_pkg;

    localparam logic [15:0] ROM0_LO = 16'h0000;
    localparam logic [15:0] ROM0_HI = 16'h3FFF;
    localparam logic [15:0] ROMX_LO = 16'h4000;
    localparam logic [15:0] ROMX_HI = 16'h7FFF;
    localparam logic [15:0] CRAM_LO = 16'hA000;
    localparam logic [15:0] CRAM_HI = 16'hBFFF;

    // Low nibble written to 0x0000-0x1FFF that unlocks cartridge RAM
    localparam logic [3:0]  RAM_EN_KEY = 4'hA;

    typedef struct packed {
        logic [4:0] bank_lo;
        logic [1:0] bank_hi;
        logic       mode;
        logic       ram_en;
    } mbc1_regs_t;

endpackage

// File: rtl/mbc1_addr_map.sv
// Combinational MBC1 bank translation: CPU address + banking regs -> linear ROM/RAM address.
module mbc1_addr_map
    import gb_cart_pkg::*;
#(
    parameter int ROM_ADDR_W = 20,
    parameter int RAM_ADDR_W = 15
) (
    input  mbc1_regs_t              regs_i,
    input  logic [15:0]             addr_i,
    output logic [ROM_ADDR_W-1:0]   rom_addr_o,
    output logic [RAM_ADDR_W-1:0]   ram_addr_o,
    output logic                    in_rom_o,
    output logic                    in_ram_o
);

    logic       in_romx;
    logic [4:0] lo_eff;
    logic [6:0] bank;
    logic [1:0] rbank;

    // Region decode and bank selection; zero test on bank_lo uses all 5 bits
    // before the bank number is truncated to the ROM width.
    always_comb begin
        in_rom_o   = (addr_i <= ROMX_HI);
        in_romx    = (addr_i >= ROMX_LO) && (addr_i <= ROMX_HI);
        in_ram_o   = (addr_i >= CRAM_LO) && (addr_i <= CRAM_HI);
        lo_eff     = (regs_i.bank_lo == 5'd0) ? 5'd1 : regs_i.bank_lo;
        if (in_romx)
            bank = {regs_i.bank_hi, lo_eff};
        else
            bank = regs_i.mode ? {regs_i.bank_hi, 5'b0} : 7'd0;
        rbank      = regs_i.mode ? regs_i.bank_hi : 2'd0;
        rom_addr_o = ROM_ADDR_W'({bank, addr_i[13:0]});
        ram_addr_o = RAM_ADDR_W'({rbank, addr_i[12:0]});
    end

endmodule

// File: rtl/mbc1_cart_responder.sv
// MBC1 cartridge responder: control-register writes, address mapping, read mux.
module mbc1_cart_responder
    import gb_cart_pkg::*;
#(
    parameter int ROM_ADDR_W = 20,
    parameter int RAM_ADDR_W = 15,
    parameter int HAS_RAM    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cart_cs,
    input  logic                    cart_rd,
    input  logic                    cart_wr,
    input  logic [15:0]             cart_addr,
    input  logic [7:0]              cart_din,
    output logic [7:0]              cart_dout,
    output logic                    cart_hit,
    output logic [ROM_ADDR_W-1:0]   rom_addr,
    output logic                    rom_rd,
    input  logic [7:0]              rom_q,
    output logic [RAM_ADDR_W-1:0]   ram_addr,
    output logic                    ram_rd,
    output logic                    ram_we,
    output logic [7:0]              ram_wdata,
    input  logic [7:0]              ram_q,
    output logic                    ram_dirty,
    input  logic                    ram_dirty_clr
);

    localparam logic HAS_RAM_B = (HAS_RAM != 0);
    localparam mbc1_regs_t REGS_RST = '{bank_lo: 5'd1, bank_hi: 2'd0, mode: 1'b0, ram_en: 1'b0};

    mbc1_regs_t regs_q, regs_d;
    logic       wr_q;
    logic       dirty_q, dirty_d;
    logic       in_rom, in_ram;
    logic       commit, ram_access;

    mbc1_addr_map #(
        .ROM_ADDR_W (ROM_ADDR_W),
        .RAM_ADDR_W (RAM_ADDR_W)
    ) u_map (
        .regs_i     (regs_q),
        .addr_i     (cart_addr),
        .rom_addr_o (rom_addr),
        .ram_addr_o (ram_addr),
        .in_rom_o   (in_rom),
        .in_ram_o   (in_ram)
    );

    // Edge-detected write commit and next-state of banking/dirty registers.
    // A held strobe commits only on its first cycle; dirty set beats clear.
    always_comb begin
        commit     = cart_cs & cart_wr & ~wr_q;
        ram_access = in_ram & regs_q.ram_en & HAS_RAM_B;
        regs_d     = regs_q;
        dirty_d    = dirty_q;
        if (ram_dirty_clr)
            dirty_d = 1'b0;
        if (commit) begin
            if (in_rom) begin
                case (cart_addr[14:13])
                    2'd0:    regs_d.ram_en  = (cart_din[3:0] == RAM_EN_KEY);
                    2'd1:    regs_d.bank_lo = cart_din[4:0];
                    2'd2:    regs_d.bank_hi = cart_din[1:0];
                    default: regs_d.mode    = cart_din[0];
                endcase
            end
            if (ram_access)
                dirty_d = 1'b1;
        end
    end

    // Register state; synchronous reset also clears the write-strobe history.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q  <= REGS_RST;
            wr_q    <= 1'b0;
            dirty_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            wr_q    <= cart_cs & cart_wr;
            dirty_q <= dirty_d;
        end
    end

    // Bus-facing strobes and read-data mux; the write pulse is masked by reset.
    always_comb begin
        cart_hit  = cart_cs & (in_rom | in_ram);
        rom_rd    = cart_cs & cart_rd & in_rom;
        ram_rd    = cart_cs & cart_rd & ram_access;
        ram_we    = commit & ram_access & ~rst;
        ram_wdata = cart_din;
        ram_dirty = dirty_q;
        if (in_rom)
            cart_dout = rom_q;
        else if (ram_access)
            cart_dout = ram_q;
        else
            cart_dout = 8'hFF;
    end

endmodule

// File: tb/tb_mbc1_cart_responder.sv
// Self-checking bench for mbc1_cart_responder against a behavioural MBC1 model.
module tb_mbc1_cart_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cart_cs, cart_rd, cart_wr;
    logic [15:0] cart_addr;
    logic [7:0]  cart_din;
    logic [7:0]  cart_dout;
    logic        cart_hit;
    logic [19:0] rom_addr;
    logic        rom_rd;
    logic [7:0]  rom_q;
    logic [14:0] ram_addr;
    logic        ram_rd, ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_q;
    logic        ram_dirty;
    logic        ram_dirty_clr;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int m_lo, m_hi, m_mode, m_en, m_dirty;

    always #5 clk = ~clk;

    function automatic logic [7:0] romf(input logic [19:0] a);
        return a[7:0] ^ a[19:12] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] ramf(input logic [14:0] a);
        return a[7:0] + {1'b0, a[14:8]} + 8'h5A;
    endfunction

    // same-cycle external memories
    assign rom_q = romf(rom_addr);
    assign ram_q = ramf(ram_addr);

    mbc1_cart_responder #(.ROM_ADDR_W(20), .RAM_ADDR_W(15), .HAS_RAM(1)) dut (
        .clk(clk), .rst(rst), .cart_cs(cart_cs), .cart_rd(cart_rd), .cart_wr(cart_wr),
        .cart_addr(cart_addr), .cart_din(cart_din), .cart_dout(cart_dout), .cart_hit(cart_hit),
        .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_q(rom_q), .ram_addr(ram_addr),
        .ram_rd(ram_rd), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q),
        .ram_dirty(ram_dirty), .ram_dirty_clr(ram_dirty_clr)
    );

    function automatic void model_reset();
        m_lo = 1; m_hi = 0; m_mode = 0; m_en = 0; m_dirty = 0;
    endfunction

    function automatic void model_commit(input int a, input int d);
        if (a < 'h2000)                     m_en = ((d % 16) == 10) ? 1 : 0;
        else if (a < 'h4000)                m_lo = d % 32;
        else if (a < 'h6000)                m_hi = d % 4;
        else if (a < 'h8000)                m_mode = d % 2;
        else if (a >= 'hA000 && a < 'hC000 && m_en == 1) m_dirty = 1;
    endfunction

    function automatic int exp_rom(input int a);
        int bank;
        if (a < 'h4000) bank = (m_mode == 1) ? m_hi * 32 : 0;
        else            bank = m_hi * 32 + ((m_lo == 0) ? 1 : m_lo);
        return (bank * 16384 + a % 16384) % (1 << 20);
    endfunction

    function automatic int exp_ram(input int a);
        return (((m_mode == 1) ? m_hi : 0) * 8192 + a % 8192) % 32768;
    endfunction

    function automatic bit is_cram(input int a);
        return (a >= 'hA000 && a < 'hC000);
    endfunction

    function automatic logic [7:0] exp_dout(input int a);
        if (a < 'h8000) return romf(20'(exp_rom(a)));
        if (is_cram(a) && m_en == 1) return ramf(15'(exp_ram(a)));
        return 8'hFF;
    endfunction

    // One-cycle write strobe followed by a low cycle; reports any ram_we seen.
    task automatic write_once(input logic [15:0] a, input logic [7:0] d,
                              output int we_cnt, output logic [14:0] we_addr, output logic [7:0] we_data);
        we_cnt = 0; we_addr = '0; we_data = '0;
        @(posedge clk); #1;
        cart_cs = 1; cart_wr = 1; cart_rd = 0; cart_addr = a; cart_din = d;
        @(negedge clk);
        if (ram_we) begin we_cnt++; we_addr = ram_addr; we_data = ram_wdata; end
        @(posedge clk); #1;
        cart_cs = 0; cart_wr = 0;
        @(negedge clk);
        if (ram_we) we_cnt++;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        int c; logic [14:0] wa; logic [7:0] wd;
        write_once(a, d, c, wa, wd);
        model_commit(int'(a), int'(d));
    endtask

    task automatic read_at(input logic [15:0] a);
        @(posedge clk); #1;
        cart_cs = 1; cart_rd = 1; cart_wr = 0; cart_addr = a;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; cart_cs = 0; cart_rd = 0; cart_wr = 0; cart_addr = 0; cart_din = 0; ram_dirty_clr = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        model_reset();
        @(negedge clk);
        checks++; if (ram_dirty !== 1'b0) begin errors++; $display("FAIL reset_dirty got %0b want 0", ram_dirty); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", ram_we); end
        read_at(16'h4123);
        checks++; if (rom_addr !== 20'h04123) begin errors++; $display("FAIL reset_rom_addr got %h want 04123", rom_addr); end
        checks++; if (rom_rd !== 1'b1 || cart_hit !== 1'b1) begin errors++; $display("FAIL reset_rom_rd got rd=%0b hit=%0b want 1 1", rom_rd, cart_hit); end
        checks++; if (cart_dout !== romf(20'h04123)) begin errors++; $display("FAIL reset_dout got %h want %h", cart_dout, romf(20'h04123)); end
    endtask

    task automatic test_bank_map();
        wr(16'h2100, 8'h00);
        read_at(16'h4000);
        checks++; if (rom_addr !== 20'h04000) begin errors++; $display("FAIL bank0_as_1 got %h want 04000", rom_addr); end
        wr(16'h2000, 8'h1F);
        wr(16'h4000, 8'h01);
        read_at(16'h7FFF);
        checks++; if (rom_addr !== 20'hFFFFF) begin errors++; $display("FAIL rom_top got %h want fffff", rom_addr); end
        read_at(16'h0000);
        checks++; if (rom_addr !== 20'h00000) begin errors++; $display("FAIL rom0_mode0 got %h want 00000", rom_addr); end
        wr(16'h6000, 8'h01);
        read_at(16'h0000);
        checks++; if (rom_addr !== 20'h80000) begin errors++; $display("FAIL rom0_mode1 got %h want 80000", rom_addr); end
    endtask

    task automatic test_ram_enable();
        int c; logic [14:0] wa; logic [7:0] wd;
        wr(16'h0000, 8'h00);
        write_once(16'hA000, 8'h55, c, wa, wd); model_commit('hA000, 'h55);
        checks++; if (c != 0) begin errors++; $display("FAIL ram_we_disabled got %0d pulses want 0", c); end
        read_at(16'hA000);
        checks++; if (cart_dout !== 8'hFF || ram_rd !== 1'b0) begin errors++; $display("FAIL ram_disabled_read got dout=%h rd=%0b want ff 0", cart_dout, ram_rd); end
        checks++; if (ram_dirty !== 1'b0) begin errors++; $display("FAIL dirty_disabled got %0b want 0", ram_dirty); end
        wr(16'h0000, 8'h0A);
        write_once(16'hA000, 8'h55, c, wa, wd); model_commit('hA000, 'h55);
        checks++; if (c != 1 || wd !== 8'h55) begin errors++; $display("FAIL ram_we_enabled got %0d pulses data %h want 1 55", c, wd); end
        checks++; if (ram_dirty !== 1'b1) begin errors++; $display("FAIL dirty_set got %0b want 1", ram_dirty); end
    endtask

    task automatic test_ram_bank();
        int c; logic [14:0] wa; logic [7:0] wd;
        wr(16'h4000, 8'h02);
        wr(16'h6000, 8'h01);
        write_once(16'hB001, 8'h77, c, wa, wd); model_commit('hB001, 'h77);
        checks++; if (c != 1 || wa !== 15'h5001) begin errors++; $display("FAIL ram_bank_mode1 got n=%0d addr=%h want 1 5001", c, wa); end
        wr(16'h6000, 8'h00);
        write_once(16'hB001, 8'h77, c, wa, wd); model_commit('hB001, 'h77);
        checks++; if (c != 1 || wa !== 15'h1001) begin errors++; $display("FAIL ram_bank_mode0 got n=%0d addr=%h want 1 1001", c, wa); end
        read_at(16'hB001);
        checks++; if (cart_dout !== ramf(15'h1001) || ram_rd !== 1'b1) begin errors++; $display("FAIL ram_read got dout=%h rd=%0b want %h 1", cart_dout, ram_rd, ramf(15'h1001)); end
    endtask

    task automatic test_held_strobe();
        @(posedge clk); #1;
        cart_cs = 1; cart_rd = 0; cart_wr = 1; cart_addr = 16'h2000; cart_din = 8'h03;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 cart_din = 8'h05;
        end
        @(posedge clk); #1 cart_wr = 0; cart_cs = 0;
        model_commit('h2000, 'h03);
        read_at(16'h4000);
        checks++; if (rom_addr !== 20'(exp_rom('h4000))) begin errors++; $display("FAIL held_once got %h want %h", rom_addr, 20'(exp_rom('h4000))); end
        wr(16'h2000, 8'h05);
        read_at(16'h4000);
        checks++; if (rom_addr !== 20'(exp_rom('h4000))) begin errors++; $display("FAIL held_recommit got %h want %h", rom_addr, 20'(exp_rom('h4000))); end
    endtask

    task automatic test_dirty_clr();
        int c;
        wr(16'h0000, 8'h0A);
        c = 0;
        @(posedge clk); #1;
        cart_cs = 1; cart_wr = 1; cart_rd = 0; cart_addr = 16'hA100; cart_din = 8'h12; ram_dirty_clr = 1;
        @(negedge clk); if (ram_we) c++;
        @(posedge clk); #1 cart_wr = 0; cart_cs = 0; ram_dirty_clr = 0;
        model_commit('hA100, 'h12);
        @(negedge clk);
        checks++; if (c != 1 || ram_dirty !== 1'b1) begin errors++; $display("FAIL clr_vs_set got we=%0d dirty=%0b want 1 1", c, ram_dirty); end
        @(posedge clk); #1 ram_dirty_clr = 1;
        @(posedge clk); #1 ram_dirty_clr = 0;
        m_dirty = 0;
        @(negedge clk);
        checks++; if (ram_dirty !== 1'b0) begin errors++; $display("FAIL dirty_clr got %0b want 0", ram_dirty); end
    endtask

    task automatic test_reset_mid();
        int c;
        wr(16'h0000, 8'h0A);
        wr(16'h2000, 8'h09);
        wr(16'h4000, 8'h03);
        @(posedge clk); #1;
        cart_cs = 1; cart_wr = 1; cart_rd = 0; cart_addr = 16'hA010; cart_din = 8'h99; rst = 1;
        @(negedge clk);
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL we_in_reset got %0b want 0", ram_we); end
        @(posedge clk); #1 rst = 0; cart_wr = 0; cart_cs = 0;
        model_reset();
        read_at(16'h4000);
        checks++; if (rom_addr !== 20'h04000 || ram_dirty !== 1'b0) begin errors++; $display("FAIL after_reset got %h dirty=%0b want 04000 0", rom_addr, ram_dirty); end
        // strobe held across reset release commits exactly once afterwards
        @(posedge clk); #1;
        cart_cs = 1; cart_wr = 1; cart_rd = 0; cart_addr = 16'h2000; cart_din = 8'h07; rst = 1;
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1 cart_din = 8'h09;
        @(posedge clk); #1 cart_din = 8'h0B;
        @(posedge clk); #1 cart_wr = 0; cart_cs = 0;
        model_reset();
        model_commit('h2000, 'h07);
        read_at(16'h4000);
        checks++; if (rom_addr !== 20'h1C000) begin errors++; $display("FAIL held_over_reset got %h want 1c000", rom_addr); end
    endtask

    task automatic test_random();
        int c, a, d, r;
        bit exp_we;
        logic [14:0] wa; logic [7:0] wd;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(1, 0) == 0) begin
                r = $urandom_range(6, 0);
                case (r)
                    0: a = $urandom_range('h1FFF, 'h0000);
                    1: a = $urandom_range('h3FFF, 'h2000);
                    2: a = $urandom_range('h5FFF, 'h4000);
                    3: a = $urandom_range('h7FFF, 'h6000);
                    4, 5: a = $urandom_range('hBFFF, 'hA000);
                    default: a = $urandom_range('hFFFF, 'h8000);
                endcase
                d = $urandom_range(255, 0);
                if (r == 0 && $urandom_range(1, 0) == 1) d = (d & 'hF0) | 'hA;
                exp_we = is_cram(a) && m_en == 1;
                write_once(16'(a), 8'(d), c, wa, wd);
                checks++;
                if (c != (exp_we ? 1 : 0) || (exp_we && (wa !== 15'(exp_ram(a)) || wd !== 8'(d)))) begin
                    errors++;
                    $display("FAIL rnd_write a=%h got n=%0d addr=%h data=%h want n=%0d addr=%h data=%h",
                             a, c, wa, wd, exp_we, 15'(exp_ram(a)), 8'(d));
                end
                model_commit(a, d);
            end else begin
                a = $urandom_range('hFFFF, 0);
                read_at(16'(a));
                checks++;
                if (cart_dout !== exp_dout(a) ||
                    cart_hit !== (a < 'h8000 || is_cram(a)) ||
                    rom_rd !== (a < 'h8000) ||
                    ram_rd !== (is_cram(a) && m_en == 1) ||
                    (a < 'h8000 && rom_addr !== 20'(exp_rom(a))) ||
                    (is_cram(a) && ram_addr !== 15'(exp_ram(a)))) begin
                    errors++;
                    $display("FAIL rnd_read a=%h got dout=%h hit=%0b rrd=%0b mrd=%0b rom=%h ram=%h want dout=%h rom=%h ram=%h",
                             a, cart_dout, cart_hit, rom_rd, ram_rd, rom_addr, ram_addr,
                             exp_dout(a), 20'(exp_rom(a)), 15'(exp_ram(a)));
                end
            end
            checks++;
            if (ram_dirty !== m_dirty[0]) begin errors++; $display("FAIL rnd_dirty got %0b want %0d", ram_dirty, m_dirty); end
        end
    endtask

    initial begin
        test_reset();
        test_bank_map();
        test_ram_enable();
        test_ram_bank();
        test_held_strobe();
        test_dirty_clr();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mbc1_cart_responder.md
Name: mbc1_cart_responder

Overview:
- Cartridge-side responder on the Work RAM/Cartridge bus (A, D, RD, WR, CS) driven by the CPU/MMU/DMA master.
- Implements the MBC1 banking controller:
  - decodes control writes in 0x0000-0x7FFF;
  - translates CPU addresses into linear ROM and cartridge-RAM addresses;
  - returns read data onto the bus.
- Backing ROM/RAM are external single-port memories clocked on ~clk, so read data is valid in the same cycle the address is presented.

Parameters:
- ROM_ADDR_W, 20, linear ROM address width. 20 gives 64 banks of 16 KiB; range 15..21. Bank-number bits above ROM_ADDR_W-14 are dropped.
- RAM_ADDR_W, 15, linear cart-RAM address width. 13 gives 1 bank, 15 gives 4 banks of 8 KiB.
- HAS_RAM, 1, when 0 all RAM accesses read 0xFF and never write.

Ports:
- clk  in  1  system clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- cart_cs  in  1  bus chip select (CS)
- cart_rd  in  1  bus read strobe (RD)
- cart_wr  in  1  bus write strobe (WR)
- cart_addr  in  16  bus address (A)
- cart_din  in  8  write data from master (D_out)
- cart_dout  out  8  read data to master (D_in)
- cart_hit  out  1  high when address is in 0x0000-0x7FFF or 0xA000-0xBFFF with cart_cs=1
- rom_addr  out  ROM_ADDR_W  linear ROM address
- rom_rd  out  1  ROM read enable
- rom_q  in  8  ROM data, same-cycle
- ram_addr  out  RAM_ADDR_W  linear cart-RAM address
- ram_rd  out  1  RAM read enable
- ram_we  out  1  RAM write pulse
- ram_wdata  out  8  RAM write data
- ram_q  in  8  RAM data, same-cycle
- ram_dirty  out  1  set by any committed RAM write (battery-save hint)
- ram_dirty_clr  in  1  clears ram_dirty

Behaviour:
- State registers and reset values:
  - bank_lo[4:0]=1, bank_hi[1:0]=0, mode=0, ram_en=0
  - ram_dirty=0, wr_q=0
- Write commit: commit = cart_cs & cart_wr & ~wr_q; wr_q <= cart_cs & cart_wr.
  - A strobe held N cycles commits exactly once, on its first cycle.
  - Re-commit requires WR or CS to drop for at least one cycle.
- Commit effects, by cart_addr:
  - 0x0000-0x1FFF: ram_en <= (cart_din[3:0]==4'hA)
  - 0x2000-0x3FFF: bank_lo <= cart_din[4:0]
  - 0x4000-0x5FFF: bank_hi <= cart_din[1:0]
  - 0x6000-0x7FFF: mode <= cart_din[0]
  - 0xA000-0xBFFF: when ram_en & HAS_RAM, ram_we=1 for that cycle only. ram_wdata=cart_din; ram_dirty <= 1.
  - Any other address: no effect.
- Effective low bank: bank_lo_eff = (bank_lo==0) ? 1 : bank_lo. The zero test uses all 5 bits, before any truncation.
- ROM mapping, all combinational:
  - 0x0000-0x3FFF: bank = mode ? {bank_hi,5'b0} : 0
  - 0x4000-0x7FFF: bank = {bank_hi, bank_lo_eff}
  - rom_addr = {bank, cart_addr[13:0]} truncated to ROM_ADDR_W
  - rom_rd = cart_cs & cart_rd & address in 0x0000-0x7FFF
- RAM mapping:
  - rbank = mode ? bank_hi : 0
  - ram_addr = {rbank, cart_addr[12:0]} truncated to RAM_ADDR_W
  - ram_rd = cart_cs & cart_rd & ram_en & HAS_RAM & address in 0xA000-0xBFFF
- cart_dout, combinational:
  - ROM region: rom_q
  - RAM region with ram_en & HAS_RAM: ram_q
  - otherwise: 0xFF (includes RAM disabled and non-cart addresses)
- Continuous reads (DMA holding RD=1 while stepping addresses) need no handshake. Data tracks the address every cycle.
- Register writes affect mapping from the cycle after commit. A read in the commit cycle uses the old banks.
- ram_dirty_clr and a RAM-write commit in the same cycle: set wins.
- Reset mid-write: all registers return to reset values. If WR is still high after reset release, wr_q=0, so the held strobe commits once.
- Reset asserted during a RAM-region commit cycle: ram_we=0 (gated by rst).

Decomposition:
- Shared package gb_cart_pkg holds:
  - region bounds ROM0_LO/HI, ROMX_LO/HI, CRAM_LO/HI
  - RAM_EN_KEY = 4'hA
  - typedef mbc1_regs_t {bank_lo, bank_hi, mode, ram_en}
- One sub-module, mbc1_addr_map: purely combinational bank/address translation from mbc1_regs_t and cart_addr, reusable for future MBC variants.
- Top level holds the registers, commit logic and read mux.

Test Plan:
- Reset, then read 0x4123 → rom_addr=0x04123; write 0x00 to 0x2100, read 0x4000 → rom_addr=0x04000 (bank 0 maps to 1).
- Write 0x1F to 0x2000 and 0x01 to 0x4000, read 0x7FFF → rom_addr=0xFFFFF. Write 0x01 to 0x6000, read 0x0000 → rom_addr=0x80000.
- RAM disabled, write 0x55 to 0xA000 → ram_we never asserts, read returns 0xFF. Write 0x0A to 0x0000, then write 0x55 to 0xA000 → one ram_we pulse, ram_dirty=1.
- Mode=1, bank_hi=2, write 0x77 to 0xB001 → ram_addr=0x5001. With mode=0 the same access → ram_addr=0x1001.
- WR held 5 cycles at 0x2000 with data changing 0x03→0x05 → bank_lo=3 only. Drop WR 1 cycle, reassert with 0x05 → bank_lo=5.
- ram_dirty_clr and a RAM write commit in the same cycle → ram_dirty stays 1. Assert rst mid-sequence → all bank registers return to reset values and the next read of 0x4000 → rom_addr=0x04000.
